// File: rtl/t_pulse_gen.sv
// Push-button front end for the T flip-flop: synchronizes and debounces the raw button,
// then emits one-cycle toggle pulses on press and, optionally, at an auto-repeat rate.
//
// state  | meaning
// IDLE   | debounced button released, waiting for a press
// HELD   | pressed, hold counter running towards the first repeat pulse
// REPEAT | auto-repeating, period counter running between repeat pulses
module t_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_in,
  input  logic             repeat_en,
  output logic             t_pulse,
  output logic             btn_state,
  output logic [CNT_W-1:0] pulse_count
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int PER_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic              r_s1;
  logic              r_s2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_btn_state;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [PER_W-1:0]  r_per_cnt;
  logic [PER_W-1:0]  w_per_nxt;
  logic              r_t_pulse;
  logic              w_pulse_nxt;
  logic [CNT_W-1:0]  r_pulse_cnt;

  logic              w_db_diff;
  logic              w_db_hit;
  logic              w_btn_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  assign w_db_diff = (r_s2 != r_btn_state);
  assign w_db_hit  = (r_db_cnt == DB_MAX);
  // Level the debouncer will hold after this edge; the FSM reacts on the same edge.
  assign w_btn_nxt = (w_db_diff && w_db_hit) ? r_s2 : r_btn_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt    <= '0;
      r_btn_state <= 1'b0;
    end else if (!w_db_diff) begin
      r_db_cnt    <= '0;
    end else if (w_db_hit) begin
      r_db_cnt    <= '0;
      r_btn_state <= r_s2;
    end else begin
      r_db_cnt    <= r_db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_per_cnt  <= '0;
      r_t_pulse  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_per_cnt  <= w_per_nxt;
      r_t_pulse  <= w_pulse_nxt;
    end
  end

  // A pulse due right after another one is held back a cycle (counter frozen) so
  // t_pulse never stays high for two consecutive cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_per_nxt   = r_per_cnt;
    w_pulse_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_btn_nxt) begin
          w_pulse_nxt = 1'b1;
          w_state_nxt = ST_HELD;
          w_hold_nxt  = '0;
        end
      end

      ST_HELD: begin
        if (!repeat_en) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == HOLD_MAX) begin
          if (!r_t_pulse) begin
            w_pulse_nxt = 1'b1;
            w_state_nxt = ST_REPEAT;
            w_per_nxt   = '0;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end

      ST_REPEAT: begin
        if (!repeat_en) begin
          w_state_nxt = ST_HELD;
          w_hold_nxt  = '0;
        end else if (r_per_cnt == PER_MAX) begin
          if (!r_t_pulse) begin
            w_pulse_nxt = 1'b1;
            w_per_nxt   = '0;
          end
        end else begin
          w_per_nxt = r_per_cnt + PER_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        w_per_nxt   = '0;
      end
    endcase

    // Release wins over everything, including a repeat pulse due on this edge.
    if (!w_btn_nxt) begin
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
      w_per_nxt   = '0;
      w_pulse_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse_cnt <= '0;
    end else if (r_t_pulse) begin
      r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
    end
  end

  assign t_pulse     = r_t_pulse;
  assign btn_state   = r_btn_state;
  assign pulse_count = r_pulse_cnt;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Scoreboard bench for t_pulse_gen: each stimulus pushes the cycle and running count of
// every pulse it should cause; a monitor pops and compares as t_pulse appears.
module tb_t_pulse_gen;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b1;
  logic       btn_in    = 1'b0;
  logic       repeat_en = 1'b0;
  logic       t_pulse;
  logic       btn_state;
  logic [7:0] pulse_count;
  logic       t_pulse_w2;
  logic       btn_state_w2;
  logic [1:0] pulse_count_w2;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt  = 0;
  bit   pend     = 1'b0;
  int   pend_cnt = 0;
  logic prev_pulse = 1'b0;

  t_pulse_gen u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (btn_in),
    .repeat_en   (repeat_en),
    .t_pulse     (t_pulse),
    .btn_state   (btn_state),
    .pulse_count (pulse_count)
  );

  // Narrow counter copy, shares all stimulus with the main instance.
  t_pulse_gen #(.CNT_W(2)) u_dut_w2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (btn_in),
    .repeat_en   (repeat_en),
    .t_pulse     (t_pulse_w2),
    .btn_state   (btn_state_w2),
    .pulse_count (pulse_count_w2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int c);
    exp_cnt++;
    exp_q.push_back('{cyc: c, cnt: exp_cnt});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input int exp);
    chk(tag, btn_state, exp);
    chk({tag, "_w2"}, btn_state_w2, exp);
  endtask

  task automatic end_scn(input string tag);
    repeat (2) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    btn_in    = 1'b0;
    repeat_en = 1'b0;
    #1;
    chk("rst_pulse", t_pulse, 0);
    chk("rst_state", btn_state, 0);
    chk("rst_count", pulse_count, 0);
    repeat (3) @(negedge clk);
    exp_cnt = 0;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("count", pulse_count, pend_cnt);
      chk("count_w2", pulse_count_w2, pend_cnt % 4);
      pend = 1'b0;
    end
    if (t_pulse === 1'b1) begin
      chk("consecutive", prev_pulse, 0);
      chk("w2_pulse", t_pulse_w2, 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        pend     = 1'b1;
        pend_cnt = e.cnt;
      end
    end
    prev_pulse = t_pulse;
  end

  initial begin
    int c;
    int p;

    @(negedge clk);
    do_reset();

    // Clean press, no repeat: single pulse after edge 15.
    wait_until(9);
    btn_in = 1'b1;
    expect_pulse(cyc + 6);
    wait_until(50);
    chk_state("t1_held_state", 1);
    chk("t1_count", pulse_count, 1);
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
    chk_state("t1_rel_state", 0);
    end_scn("t1_queue");

    // Bounce then settle; then a 2-cycle glitch while held.
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      btn_in = (i % 2 == 0);
      @(negedge clk);
    end
    btn_in = 1'b1;
    c = cyc;
    expect_pulse(c + 6);
    wait_until(c + 20);
    chk_state("t2_settled", 1);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("t2_glitch_a", 1);
    repeat (8) @(negedge clk);
    chk_state("t2_glitch_b", 1);
    chk("t2_count", pulse_count, 1);
    btn_in = 1'b0;
    repeat (12) @(negedge clk);
    chk_state("t2_rel_state", 0);
    end_scn("t2_queue");

    // Auto-repeat; release lands on the edge of a due repeat pulse.
    do_reset();
    repeat_en = 1'b1;
    repeat (3) @(negedge clk);
    btn_in = 1'b1;
    p = cyc + 6;
    expect_pulse(p);
    for (int k = 16; k <= 48; k += 8) expect_pulse(p + k);
    wait_until(p + 50);
    btn_in = 1'b0;
    wait_until(p + 70);
    chk_state("t3_rel_state", 0);
    chk("t3_count", pulse_count, 6);
    end_scn("t3_queue");

    // repeat_en dropped mid-repeat, then restored.
    do_reset();
    repeat_en = 1'b1;
    repeat (3) @(negedge clk);
    btn_in = 1'b1;
    p = cyc + 6;
    expect_pulse(p);
    expect_pulse(p + 16);
    expect_pulse(p + 46);
    expect_pulse(p + 54);
    wait_until(p + 20);
    repeat_en = 1'b0;
    wait_until(p + 30);
    repeat_en = 1'b1;
    wait_until(p + 50);
    btn_in = 1'b0;
    wait_until(p + 70);
    chk("t4_count", pulse_count, 4);
    end_scn("t4_queue");

    // Reset in the middle of a held press.
    do_reset();
    repeat_en = 1'b1;
    repeat (3) @(negedge clk);
    btn_in = 1'b1;
    p = cyc + 6;
    expect_pulse(p);
    expect_pulse(p + 16);
    wait_until(p + 18);
    chk("t5_pre_count", pulse_count, 2);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_pulse", t_pulse, 0);
    chk("t5_rst_state", btn_state, 0);
    chk("t5_rst_count", pulse_count, 0);
    wait_until(p + 21);
    reset_n = 1'b1;
    exp_cnt = 0;
    c = cyc;
    expect_pulse(c + 6);
    wait_until(c + 16);
    btn_in = 1'b0;
    wait_until(c + 35);
    chk("t5_count", pulse_count, 1);
    end_scn("t5_queue");

    // Five presses: narrow counter wraps 1,2,3,0,1.
    do_reset();
    repeat (3) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      btn_in = 1'b1;
      expect_pulse(cyc + 6);
      repeat (15) @(negedge clk);
      btn_in = 1'b0;
      repeat (15) @(negedge clk);
    end
    chk("t6_count", pulse_count, 5);
    chk("t6_count_w2", pulse_count_w2, 1);
    end_scn("t6_queue");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
